key_switch_detect_multi: RTL and testbench

Parametrised N-channel push-button front end for the ThreeColorLight controller. Each channel synchronises a raw key input, debounces it with a per-channel FSM, and produces a debounced level plus press, release and long-press pulses. It also produces a toggling "fake switch" level, so that one push button acts as a latching switch. It sits between the board keys and the light-mode controller and replaces the single-purpose switch detector.

---
 rtl/key_detect_pkg.sv | 17 +
 rtl/key_switch_detect_multi_if.sv | 25 ++
 rtl/key_channel_fsm.sv | 128 ++++++++++++
 rtl/key_switch_detect_multi.sv | 47 ++++
 tb/tb_key_switch_detect_multi.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_detect_pkg.sv
// Shared types for the key switch detector.
// State encoding and counter sizing helper.
package key_detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG,
    RELEASE_WAIT
  } key_state_t;

  function automatic int cnt_width(input int long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/key_switch_detect_multi_if.sv
// Key bank bus: raw keys and clear in, debounced events out.
// master = board/controller side, slave = detector.
interface key_switch_detect_multi_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] Key;
  logic              Clr_Switch;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] fake_switch;

  modport master (
    output Key, Clr_Switch,
    input  key_level, press_pulse, release_pulse,
    input  long_pulse, fake_switch
  );

  modport slave (
    input  Key, Clr_Switch,
    output key_level, press_pulse, release_pulse,
    output long_pulse, fake_switch
  );
endinterface

// File: rtl/key_channel_fsm.sv
// One key channel: synchroniser, polarity fix, debounce FSM,
// saturating counter and long-press bookkeeping.
module key_channel_fsm
  import key_detect_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_HIGH     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic press_hit
);

  localparam int CW = cnt_width(LONG_CYCLES);
  localparam logic INV = (ACTIVE_HIGH == 0);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0] sync;
  logic       act;

  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          was_long, was_long_nxt;
  logic          release_hit, long_hit;

  // Flops reset to the idle key level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {2{INV}};
    else     sync <= {sync[0], key};
  end

  assign act     = sync[1] ^ INV;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      was_long      <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      was_long      <= was_long_nxt;
      press_pulse   <= press_hit;
      release_pulse <= release_hit;
      long_pulse    <= long_hit;
      if (press_hit)        level <= 1'b1;
      else if (release_hit) level <= 1'b0;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    was_long_nxt = was_long;
    unique case (state)
      IDLE: begin
        if (act) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (!act) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = ONE;
        end else if (cnt == LONG_LAST) begin
          state_nxt    = LONG;
          was_long_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LONG: begin
        if (!act) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_nxt = was_long ? LONG : HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt    = IDLE;
          cnt_nxt      = '0;
          was_long_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    press_hit   = (state == PRESS_WAIT) && act && (cnt == DEB_LAST);
    release_hit = (state == RELEASE_WAIT) && !act && (cnt == DEB_LAST);
    long_hit    = (state == HELD) && act && (cnt == LONG_LAST);
  end

endmodule

// File: rtl/key_switch_detect_multi.sv
// N-channel push-button front end with latching fake switches.
module key_switch_detect_multi
  import key_detect_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_HIGH     = 1
) (
  input logic                 Sys_CLK,
  input logic                 Sys_RST,
  key_switch_detect_multi_if.slave bus
);

  logic [N_KEYS-1:0] lvl, pp, rp, lp, hit, fake;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_HIGH    (ACTIVE_HIGH)
    ) u_ch (
      .clk          (Sys_CLK),
      .rst          (Sys_RST),
      .key          (bus.Key[i]),
      .level        (lvl[i]),
      .press_pulse  (pp[i]),
      .release_pulse(rp[i]),
      .long_pulse   (lp[i]),
      .press_hit    (hit[i])
    );
  end

  // Toggle lands on the same edge as press_pulse; clear wins.
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST)             fake <= '0;
    else if (bus.Clr_Switch) fake <= '0;
    else                     fake <= fake ^ hit;
  end

  assign bus.key_level     = lvl;
  assign bus.press_pulse   = pp;
  assign bus.release_pulse = rp;
  assign bus.long_pulse    = lp;
  assign bus.fake_switch   = fake;

endmodule

// File: tb/tb_key_switch_detect_multi.sv
// Bench for key_switch_detect_multi: directed scenarios plus
// random key traffic against a run-length reference model.
module tb_key_switch_detect_multi;
  localparam int NK  = 2;
  localparam int DEB = 4;
  localparam int LNG = 16;

  logic Sys_CLK = 1'b0;
  logic Sys_RST = 1'b0;

  key_switch_detect_multi_if #(.N_KEYS(NK)) bus ();

  key_switch_detect_multi #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG),
    .ACTIVE_HIGH    (1)
  ) dut (
    .Sys_CLK(Sys_CLK),
    .Sys_RST(Sys_RST),
    .bus    (bus)
  );

  always #10 Sys_CLK = ~Sys_CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: a key flips state after DEB consecutive disagreeing
  // samples; long fires once per press after LNG unbroken held samples.
  logic [NK-1:0] h1, h2, pr, lf, br, ep, er, el, ef;
  int run [NK];
  int hold[NK];
  logic ma;

  wire [5*NK-1:0] obs = {bus.key_level, bus.press_pulse,
                         bus.release_pulse, bus.long_pulse,
                         bus.fake_switch};
  wire [5*NK-1:0] expv = {pr, ep, er, el, ef};

  task automatic model_reset();
    h1 = '0; h2 = '0; pr = '0; lf = '0; br = '0;
    ep = '0; er = '0; el = '0; ef = '0;
    for (int c = 0; c < NK; c++) begin
      run[c] = 0; hold[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NK; c++) begin
      ma = h2[c];
      ep[c] = 1'b0; er[c] = 1'b0; el[c] = 1'b0;
      if (!pr[c]) begin
        run[c] = ma ? run[c] + 1 : 0;
        if (run[c] == DEB) begin
          pr[c] = 1'b1; run[c] = 0; ep[c] = 1'b1;
          hold[c] = 0; br[c] = 1'b0; lf[c] = 1'b0;
        end
      end else begin
        if (!ma) begin
          run[c]++; br[c] = 1'b1;
        end else begin
          run[c] = 0;
          if (br[c]) begin hold[c] = 0; br[c] = 1'b0; end
          else hold[c]++;
        end
        if (run[c] == DEB) begin
          pr[c] = 1'b0; run[c] = 0; er[c] = 1'b1;
        end else if (ma && hold[c] == LNG && !lf[c]) begin
          el[c] = 1'b1; lf[c] = 1'b1;
        end
      end
    end
    ef = bus.Clr_Switch ? '0 : (ef ^ ep);
    h2 = h1;
    h1 = bus.Key;
  endtask

  task automatic tick();
    @(posedge Sys_CLK);
    if (!Sys_RST) model_step();
    @(negedge Sys_CLK);
    cyc++;
  endtask

  task automatic do_reset();
    bus.Key = '0;
    bus.Clr_Switch = 1'b0;
    Sys_RST = 1'b1;
    model_reset();
    tick(); tick();
    Sys_RST = 1'b0;
  endtask

  task automatic test_reset();
    int t0, first;
    bus.Key = 2'b11;
    bus.Clr_Switch = 1'b0;
    Sys_RST = 1'b1;
    model_reset();
    tick(); tick();
    if (obs !== '0) begin
      bad++; $display("FAIL rst_outputs got=%b want=0", obs);
    end
    total++;
    Sys_RST = 1'b0;
    t0 = cyc; first = -1;
    repeat (10) begin
      tick();
      if (obs !== expv) begin
        bad++; $display("FAIL rst_model cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      total++;
      if (first < 0 && bus.press_pulse == 2'b11) first = cyc - t0;
    end
    if (first != 6) begin
      bad++; $display("FAIL rst_press_latency got=%0d want=6", first);
    end
    total++;
    if ({bus.key_level, bus.fake_switch} !== 4'b1111) begin
      bad++; $display("FAIL rst_levels got=%b want=1111",
                      {bus.key_level, bus.fake_switch});
    end
    total++;
  endtask

  task automatic test_glitch();
    int np;
    do_reset();
    np = 0;
    bus.Key = 2'b01;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) bus.Key = 2'b00;
      tick();
      if (obs !== expv) begin
        bad++; $display("FAIL glitch_model cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      total++;
      np += int'(|{bus.press_pulse, bus.release_pulse, bus.long_pulse});
    end
    if (np != 0 || bus.fake_switch[0] !== 1'b0) begin
      bad++; $display("FAIL glitch_quiet pulses=%0d fake0=%b want 0/0",
                      np, bus.fake_switch[0]);
    end
    total++;
  endtask

  task automatic test_long();
    int t0, tf, tp, tl, tr, np, nl, nr;
    do_reset();
    np = 0; nl = 0; nr = 0; tp = -1; tl = -1; tr = -1;
    bus.Key = 2'b01; t0 = cyc; tf = 0;
    for (int i = 0; i < 42; i++) begin
      if (i == 30) begin bus.Key = 2'b00; tf = cyc; end
      tick();
      if (obs !== expv) begin
        bad++; $display("FAIL long_model cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      total++;
      if (bus.press_pulse[0])   begin np++; tp = cyc; end
      if (bus.long_pulse[0])    begin nl++; tl = cyc; end
      if (bus.release_pulse[0]) begin nr++; tr = cyc; end
    end
    if (np != 1 || nl != 1 || nr != 1) begin
      bad++; $display("FAIL long_counts got=%0d/%0d/%0d want=1/1/1", np, nl, nr);
    end
    total++;
    if (tp - t0 != 6) begin
      bad++; $display("FAIL long_press_lat got=%0d want=6", tp - t0);
    end
    total++;
    if (tl - tp != 16) begin
      bad++; $display("FAIL long_delay got=%0d want=16", tl - tp);
    end
    total++;
    if (tr - tf != 6) begin
      bad++; $display("FAIL long_release_lat got=%0d want=6", tr - tf);
    end
    total++;
  endtask

  task automatic test_toggle();
    logic f1;
    int nl;
    do_reset();
    nl = 0; f1 = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bus.Key = 2'b10;
      for (int i = 0; i < 28; i++) begin
        if (i == 8) bus.Key = 2'b00;
        tick();
        if (obs !== expv) begin
          bad++; $display("FAIL toggle_model cyc=%0d got=%b want=%b", cyc, obs, expv);
        end
        total++;
        nl += int'(bus.long_pulse[1]);
      end
      if (p == 0) f1 = bus.fake_switch[1];
    end
    if ({f1, bus.fake_switch[1]} !== 2'b10 || nl != 0) begin
      bad++; $display("FAIL toggle_seq got=%b long=%0d want=10 long=0",
                      {f1, bus.fake_switch[1]}, nl);
    end
    total++;
  endtask

  task automatic test_bounce();
    int nl, nr;
    do_reset();
    nl = 0; nr = 0;
    bus.Key = 2'b01;
    for (int i = 0; i < 52; i++) begin
      if (i == 26) bus.Key = 2'b00;
      if (i == 28) bus.Key = 2'b01;
      tick();
      if (obs !== expv) begin
        bad++; $display("FAIL bounce_model cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      total++;
      nl += int'(bus.long_pulse[0]);
      nr += int'(bus.release_pulse[0]);
    end
    if (nl != 1 || nr != 0 || bus.key_level[0] !== 1'b1) begin
      bad++; $display("FAIL bounce_hold long=%0d rel=%0d lvl=%b want 1/0/1",
                      nl, nr, bus.key_level[0]);
    end
    total++;
    bus.Key = 2'b00;
    repeat (10) begin
      tick();
      if (obs !== expv) begin
        bad++; $display("FAIL bounce_release cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      total++;
    end
  endtask

  task automatic test_clear();
    int t0, nr;
    do_reset();
    bus.Key = 2'b01;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) bus.Key = 2'b00;
      tick();
    end
    if (bus.fake_switch !== 2'b01) begin
      bad++; $display("FAIL clr_setup got=%b want=01", bus.fake_switch);
    end
    total++;
    bus.Key = 2'b01; t0 = cyc;
    repeat (6) begin
      tick();
      if (cyc == t0 + 5) bus.Clr_Switch = 1'b1;
    end
    if ({bus.press_pulse[0], bus.fake_switch} !== 3'b100) begin
      bad++; $display("FAIL clr_priority got=%b want=100",
                      {bus.press_pulse[0], bus.fake_switch});
    end
    total++;
    bus.Clr_Switch = 1'b0;
    repeat (3) tick();
    Sys_RST = 1'b1;
    model_reset();
    #1;
    if (obs !== '0) begin
      bad++; $display("FAIL rst_mid_held got=%b want=0", obs);
    end
    total++;
    tick();
    bus.Key = 2'b00;
    Sys_RST = 1'b0;
    nr = 0;
    repeat (12) begin
      tick();
      nr += int'(|bus.release_pulse);
    end
    if (nr != 0) begin
      bad++; $display("FAIL rst_no_release got=%0d want=0", nr);
    end
    total++;
  endtask

  task automatic test_random();
    int left[NK];
    do_reset();
    for (int c = 0; c < NK; c++) left[c] = 0;
    repeat (900) begin
      for (int c = 0; c < NK; c++) begin
        if (left[c] == 0) begin
          bus.Key[c] = ~bus.Key[c];
          left[c] = ($urandom_range(0, 3) == 0) ?
                    int'($urandom_range(10, 30)) : int'($urandom_range(1, 7));
        end
        left[c]--;
      end
      bus.Clr_Switch = ($urandom_range(0, 39) == 0);
      tick();
      if (obs !== expv) begin
        bad++; $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      total++;
    end
    bus.Clr_Switch = 1'b0;
  endtask

  initial begin
    bus.Key = '0;
    bus.Clr_Switch = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_glitch();
    test_long();
    test_toggle();
    test_bounce();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
